// File: rtl/cnt_pkg.sv
// Shared definitions for the counter command scheduler, its counter and scoreboard.
package cnt_pkg;

  // Counter mode encodings
  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_SETTLE = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Round-robin pick: on contention the requester that did not own the counter last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_owner);
    if (req0 && req1) begin
      return ~last_owner;
    end
    return req1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: turns two requests plus last owner into a grant index.
module rr_arb2
  import cnt_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  output logic valid_o,
  output logic idx_o
);

  // Any request is grantable; the index alternates only under contention
  always_comb begin
    valid_o = req0_i | req1_i;
    idx_o   = rr_pick(req0_i, req1_i, last_owner_i);
  end

endmodule

// File: rtl/cnt_cmd_sched.sv
// Round-robin command scheduler sharing one 4-bit counter between two requesters.
module cnt_cmd_sched
  import cnt_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_i,
  input  logic [1:0]       modo0_i,
  input  logic [3:0]       d0_i,
  input  logic [LEN_W-1:0] len0_i,
  output logic             gnt0_o,
  output logic             done0_o,
  input  logic             req1_i,
  input  logic [1:0]       modo1_i,
  input  logic [3:0]       d1_i,
  input  logic [LEN_W-1:0] len1_i,
  output logic             gnt1_o,
  output logic             done1_o,
  output logic             enable_o,
  output logic [1:0]       modo_o,
  output logic [3:0]       d_o,
  input  logic             rco_i,
  input  logic [3:0]       q_i,
  output logic [3:0]       q_res_o,
  output logic             err_o,
  output logic             busy_o
);

  // Wide enough to count both a full len and the TIMEOUT limit
  localparam int unsigned CntW = LEN_W + 6;
  localparam logic [CntW-1:0] TimeoutC = CntW'(TIMEOUT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       modo_q, modo_d;
  logic [3:0]       d_q, d_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CntW-1:0]  run_cnt_q, run_cnt_d;
  logic             err_pend_q, err_pend_d;
  logic [3:0]       q_res_q, q_res_d;
  logic             gnt_q, gnt_d;

  logic             arb_valid;
  logic             arb_idx;
  logic [CntW-1:0]  cnt_inc;
  logic [CntW-1:0]  len_ext;

  rr_arb2 u_arb (
    .req0_i       (req0_i),
    .req1_i       (req1_i),
    .last_owner_i (last_owner_q),
    .valid_o      (arb_valid),
    .idx_o        (arb_idx)
  );

  // Saturating enable-cycle count including the current RUN edge
  always_comb begin
    cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CntW'(1);
    len_ext = CntW'(len_q);
  end

  // Next-state logic: grant, run, settle, respond
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    modo_d       = modo_q;
    d_d          = d_q;
    len_d        = len_q;
    run_cnt_d    = run_cnt_q;
    err_pend_d   = err_pend_q;
    q_res_d      = q_res_q;
    gnt_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d      = ST_RUN;
          owner_d      = arb_idx;
          last_owner_d = arb_idx;
          modo_d       = arb_idx ? modo1_i : modo0_i;
          d_d          = arb_idx ? d1_i : d0_i;
          len_d        = arb_idx ? len1_i : len0_i;
          run_cnt_d    = '0;
          err_pend_d   = 1'b0;
          gnt_d        = 1'b1;
        end
      end
      ST_RUN: begin
        run_cnt_d = cnt_inc;
        if (modo_q == MODO_LOAD) begin
          state_d = ST_SETTLE;
        end else if (len_q != '0) begin
          if (cnt_inc == len_ext) begin
            state_d = ST_SETTLE;
          end
        end else if (rco_i) begin
          state_d = ST_SETTLE;
        end else if (cnt_inc == TimeoutC) begin
          err_pend_d = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        q_res_d = q_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      modo_q       <= MODO_UP;
      d_q          <= '0;
      len_q        <= '0;
      run_cnt_q    <= '0;
      err_pend_q   <= 1'b0;
      q_res_q      <= '0;
      gnt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      modo_q       <= modo_d;
      d_q          <= d_d;
      len_q        <= len_d;
      run_cnt_q    <= run_cnt_d;
      err_pend_q   <= err_pend_d;
      q_res_q      <= q_res_d;
      gnt_q        <= gnt_d;
    end
  end

  // Outputs decode straight from state so reset drops them immediately
  always_comb begin
    gnt0_o   = gnt_q & ~owner_q;
    gnt1_o   = gnt_q & owner_q;
    done0_o  = (state_q == ST_RESP) & ~owner_q;
    done1_o  = (state_q == ST_RESP) & owner_q;
    err_o    = (state_q == ST_RESP) & err_pend_q;
    enable_o = (state_q == ST_RUN);
    busy_o   = (state_q != ST_IDLE);
    modo_o   = modo_q;
    d_o      = d_q;
    q_res_o  = q_res_q;
  end

endmodule

// File: tb/tb_cnt_cmd_sched.sv
// Directed bench for cnt_cmd_sched with a behavioural 4-bit counter attached.
module tb_cnt_cmd_sched;
  import cnt_pkg::*;

  localparam int unsigned LenW = 4;
  localparam int unsigned Tmo  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req0 = 1'b0, req1 = 1'b0;
  logic [1:0]      modo0 = '0, modo1 = '0;
  logic [3:0]      d0 = '0, d1 = '0;
  logic [LenW-1:0] len0 = '0, len1 = '0;
  logic            gnt0, gnt1, done0, done1, enable, rco, err, busy;
  logic [1:0]      modo;
  logic [3:0]      d, q, q_res;

  logic [3:0]      cq = 4'h0;
  logic            rco_raw;
  logic            rco_hold0 = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cnt_cmd_sched #(.LEN_W(LenW), .TIMEOUT(Tmo)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .req0_i   (req0),
    .modo0_i  (modo0),
    .d0_i     (d0),
    .len0_i   (len0),
    .gnt0_o   (gnt0),
    .done0_o  (done0),
    .req1_i   (req1),
    .modo1_i  (modo1),
    .d1_i     (d1),
    .len1_i   (len1),
    .gnt1_o   (gnt1),
    .done1_o  (done1),
    .enable_o (enable),
    .modo_o   (modo),
    .d_o      (d),
    .rco_i    (rco),
    .q_i      (q),
    .q_res_o  (q_res),
    .err_o    (err),
    .busy_o   (busy)
  );

  // Counter model driven by the scheduler
  always @(posedge clk) begin
    if (enable) begin
      case (modo)
        MODO_UP:   cq <= cq + 4'd1;
        MODO_DOWN: cq <= cq - 4'd1;
        MODO_UP3:  cq <= cq + 4'd3;
        default:   cq <= d;
      endcase
    end
  end

  always_comb begin
    rco_raw = 1'b0;
    case (modo)
      MODO_UP:   rco_raw = (cq == 4'hF);
      MODO_DOWN: rco_raw = (cq == 4'h0);
      MODO_UP3:  rco_raw = (cq >= 4'hD);
      default:   rco_raw = 1'b0;
    endcase
    rco = rco_hold0 ? 1'b0 : rco_raw;
    q   = cq;
  end

  typedef struct {
    logic       owner;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] len;
    logic       hold0;
    logic [3:0] exp_q;
    int         exp_en;
    logic       exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic owner, input logic [1:0] m, input logic [3:0] dv,
                       input logic [3:0] l);
    if (owner) begin
      req1 = 1'b1; modo1 = m; d1 = dv; len1 = l;
    end else begin
      req0 = 1'b1; modo0 = m; d0 = dv; len0 = l;
    end
  endtask

  task automatic wait_gnt(output int who);
    int n;
    n = 0;
    who = -1;
    while (who < 0 && n < 16) begin
      @(negedge clk);
      n++;
      if (gnt0) who = 0;
      else if (gnt1) who = 1;
    end
  endtask

  task automatic wait_done(output int who);
    int n;
    n = 0;
    who = -1;
    while (who < 0 && n < 64) begin
      @(negedge clk);
      n++;
      if (done0) who = 0;
      else if (done1) who = 1;
    end
  endtask

  // One table command: grant latency, enable cycles, done latency, result, error
  task automatic run_vec(input vec_t v, input int idx);
    int   waited, en_cnt, lat;
    logic got_gnt, got_done;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    rco_hold0 = v.hold0;
    drive(v.owner, v.modo, v.d, v.len);
    got_gnt = 1'b0;
    waited  = 0;
    while (!got_gnt && waited < 8) begin
      @(negedge clk);
      waited++;
      if (v.owner ? gnt1 : gnt0) got_gnt = 1'b1;
    end
    check({tag, "_gnt_wait"}, waited, 1);
    check({tag, "_other_gnt"}, int'(v.owner ? gnt0 : gnt1), 0);
    req0 = 1'b0;
    req1 = 1'b0;
    en_cnt   = 0;
    lat      = 0;
    got_done = 1'b0;
    while (!got_done && lat < 64) begin
      if (enable) en_cnt++;
      if (v.owner ? done1 : done0) got_done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_en_cycles"}, en_cnt, v.exp_en);
    check({tag, "_done_lat"}, lat, v.exp_en + 1);
    check({tag, "_q_res"}, int'(q_res), int'(v.exp_q));
    check({tag, "_err"}, int'(err), int'(v.exp_err));
    check({tag, "_other_done"}, int'(v.owner ? done0 : done1), 0);
    @(negedge clk);
    check({tag, "_busy_after"}, int'(busy), 0);
    rco_hold0 = 1'b0;
  endtask

  initial begin
    int w;

    tbl[0] = '{owner: 1'b0, modo: MODO_LOAD, d: 4'hA, len: 4'd0, hold0: 1'b0,
               exp_q: 4'hA, exp_en: 1, exp_err: 1'b0};
    tbl[1] = '{owner: 1'b1, modo: MODO_LOAD, d: 4'h0, len: 4'd3, hold0: 1'b0,
               exp_q: 4'h0, exp_en: 1, exp_err: 1'b0};
    tbl[2] = '{owner: 1'b1, modo: MODO_UP, d: 4'h0, len: 4'd5, hold0: 1'b0,
               exp_q: 4'h5, exp_en: 5, exp_err: 1'b0};
    tbl[3] = '{owner: 1'b0, modo: MODO_LOAD, d: 4'hD, len: 4'd0, hold0: 1'b0,
               exp_q: 4'hD, exp_en: 1, exp_err: 1'b0};
    tbl[4] = '{owner: 1'b0, modo: MODO_UP, d: 4'h0, len: 4'd0, hold0: 1'b0,
               exp_q: 4'h0, exp_en: 3, exp_err: 1'b0};
    tbl[5] = '{owner: 1'b1, modo: MODO_LOAD, d: 4'h3, len: 4'd7, hold0: 1'b0,
               exp_q: 4'h3, exp_en: 1, exp_err: 1'b0};
    tbl[6] = '{owner: 1'b1, modo: MODO_DOWN, d: 4'h0, len: 4'd2, hold0: 1'b0,
               exp_q: 4'h1, exp_en: 2, exp_err: 1'b0};
    tbl[7] = '{owner: 1'b0, modo: MODO_UP3, d: 4'h0, len: 4'd2, hold0: 1'b0,
               exp_q: 4'h7, exp_en: 2, exp_err: 1'b0};
    tbl[8] = '{owner: 1'b0, modo: MODO_LOAD, d: 4'h0, len: 4'd0, hold0: 1'b0,
               exp_q: 4'h0, exp_en: 1, exp_err: 1'b0};
    tbl[9] = '{owner: 1'b1, modo: MODO_UP, d: 4'h0, len: 4'd0, hold0: 1'b1,
               exp_q: 4'h8, exp_en: 8, exp_err: 1'b1};

    // Reset values
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_enable", int'(enable), 0);
    check("rst_gnt", int'({gnt0, gnt1}), 0);
    check("rst_done", int'({done0, done1}), 0);
    check("rst_q_res", int'(q_res), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_modo_d", int'({modo, d}), 0);

    // Contention from reset: requester 0 first, then strict alternation
    drive(1'b0, MODO_LOAD, 4'h5, 4'd0);
    drive(1'b1, MODO_LOAD, 4'h9, 4'd0);
    reset = 1'b0;
    wait_gnt(w);
    check("cont_gnt_a", w, 0);
    req0 = 1'b0;
    wait_done(w);
    check("cont_done_a", w, 0);
    check("cont_q_a", int'(q_res), 5);
    wait_gnt(w);
    check("cont_gnt_b", w, 1);
    req1 = 1'b0;
    wait_done(w);
    check("cont_done_b", w, 1);
    check("cont_q_b", int'(q_res), 9);
    @(negedge clk);
    drive(1'b0, MODO_LOAD, 4'h2, 4'd0);
    drive(1'b1, MODO_LOAD, 4'h4, 4'd0);
    wait_gnt(w);
    check("cont_gnt_c", w, 0);
    req0 = 1'b0;
    wait_done(w);
    check("cont_done_c", w, 0);
    wait_gnt(w);
    check("cont_gnt_d", w, 1);
    req1 = 1'b0;
    wait_done(w);
    check("cont_done_d", w, 1);
    check("cont_q_d", int'(q_res), 4);
    @(negedge clk);

    // Table of single-owner commands
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], i);
    end

    // Reset asserted on the second enable cycle of a requester-0 command
    @(negedge clk);
    drive(1'b0, MODO_UP, 4'h0, 4'd6);
    wait_gnt(w);
    check("mid_gnt", w, 0);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("mid_pre_enable", int'(enable), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_enable", int'(enable), 0);
    check("mid_gnt_low", int'({gnt0, gnt1}), 0);
    check("mid_busy", int'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_no_done", int'({done0, done1}), 0);
    end
    drive(1'b0, MODO_LOAD, 4'h6, 4'd0);
    drive(1'b1, MODO_LOAD, 4'hB, 4'd0);
    reset = 1'b0;
    wait_gnt(w);
    check("post_rst_gnt", w, 0);
    req0 = 1'b0;
    wait_done(w);
    check("post_rst_done", w, 0);
    check("post_rst_q", int'(q_res), 6);
    wait_gnt(w);
    check("post_rst_gnt_b", w, 1);
    req1 = 1'b0;
    wait_done(w);
    check("post_rst_done_b", w, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
